// File: rtl/tx_framer_pkg.sv
// Shared definitions for the AXI-Stream TX framer: sync byte, header field layout,
// FSM state encoding and the header packing helper.
package tx_framer_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         HDR_SYNC_LSB  = 24;
    localparam int         HDR_SEQ_LSB   = 16;
    localparam int         HDR_TRUNC_BIT = 15;
    localparam int         HDR_LEN_LSB   = 0;
    localparam int         HDR_LEN_W     = 12;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_TRL     = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    function automatic logic [31:0] make_header(input logic [7:0]           seq,
                                                input logic                 trunc,
                                                input logic [HDR_LEN_W-1:0] len);
        logic [31:0] hdr;
        hdr                           = 32'h0000_0000;
        hdr[HDR_SYNC_LSB +: 8]        = SYNC_BYTE;
        hdr[HDR_SEQ_LSB +: 8]         = seq;
        hdr[HDR_TRUNC_BIT]            = trunc;
        hdr[HDR_LEN_LSB +: HDR_LEN_W] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/tx_frame_ram.sv
// Payload buffer for the TX framer: simple dual-port RAM, one write port and a
// registered synchronous read port (one cycle read latency).
module tx_frame_ram
    import tx_framer_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axis_tx_framer.sv
// Store-and-forward AXI-Stream framer: buffers one payload frame, then emits header,
// payload and (when TX_FRAMER_CSUM_EN is defined) a 32-bit additive checksum trailer.
module axis_tx_framer
    import tx_framer_pkg::*;
#(
    parameter int U_DLY      = 1,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        axis_clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] frame_cnt,
    output logic        drop_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    state_t        state_r, state_nxt;
    logic          drop_act_r, drop_act_nxt;
    logic          s_ready_r, s_ready_nxt;
    logic          m_valid_r, m_valid_nxt;
    logic [31:0]   m_data_r, m_data_nxt;
    logic          m_last_r, m_last_nxt;
    logic [15:0]   frame_cnt_r, frame_cnt_nxt;
    logic          drop_pulse_r, drop_pulse_nxt;
    logic [7:0]    seq_r, seq_nxt;
    logic [CW-1:0] wr_cnt_r, wr_cnt_nxt;
    logic [CW-1:0] len_r, len_nxt;
    logic [CW-1:0] out_idx_r, out_idx_nxt;
    logic [AW-1:0] rd_ptr_r, rd_ptr_nxt;
    logic [31:0]   first_r, first_nxt;
`ifdef TX_FRAMER_CSUM_EN
    logic [31:0]   csum_r, csum_nxt;
`endif

    logic          s_hs_s;
    logic          m_hs_s;
    logic          wr_en_s;
    logic          frame_end_s;
    logic [31:0]   ram_q_s;

    assign s_hs_s = s_axis_tvalid & s_ready_r;
    assign m_hs_s = m_valid_r & m_axis_tready;

    // Word 0 is served from first_r so a one-word frame never races its own write;
    // the RAM address is driven with rd_ptr_nxt so ram_q_s always holds mem[rd_ptr_r].
    tx_frame_ram #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (axis_clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_cnt_r[AW-1:0]),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr_nxt),
        .rd_data (ram_q_s)
    );

    // Next-state, ingress write control and egress output register loading.
    always_comb begin
        state_nxt      = state_r;
        m_valid_nxt    = m_valid_r;
        m_data_nxt     = m_data_r;
        m_last_nxt     = m_last_r;
        frame_cnt_nxt  = frame_cnt_r;
        drop_pulse_nxt = 1'b0;
        seq_nxt        = seq_r;
        wr_cnt_nxt     = wr_cnt_r;
        len_nxt        = len_r;
        out_idx_nxt    = out_idx_r;
        rd_ptr_nxt     = rd_ptr_r;
        first_nxt      = first_r;
        wr_en_s        = 1'b0;
        frame_end_s    = 1'b0;
`ifdef TX_FRAMER_CSUM_EN
        csum_nxt       = csum_r;
`endif

        // Discarding of a truncated frame's tail runs alongside egress.
        if (drop_act_r && s_hs_s && s_axis_tlast) begin
            drop_act_nxt = 1'b0;
        end else begin
            drop_act_nxt = drop_act_r;
        end

        case (state_r)
            ST_FILL: begin
                if (s_hs_s) begin
                    wr_en_s    = 1'b1;
                    wr_cnt_nxt = wr_cnt_r + CW'(1);
`ifdef TX_FRAMER_CSUM_EN
                    csum_nxt   = csum_r + s_axis_tdata;
`endif
                    if (wr_cnt_r == CW'(0)) begin
                        first_nxt = s_axis_tdata;
                    end else begin
                        first_nxt = first_r;
                    end
                    if (s_axis_tlast || (wr_cnt_r == CW'(FIFO_DEPTH - 1))) begin
                        state_nxt      = ST_HDR;
                        len_nxt        = wr_cnt_r + CW'(1);
                        drop_act_nxt   = ~s_axis_tlast;
                        drop_pulse_nxt = ~s_axis_tlast;
                        m_valid_nxt    = 1'b1;
                        m_last_nxt     = 1'b0;
                        m_data_nxt     = make_header(seq_r, ~s_axis_tlast,
                                                     HDR_LEN_W'(wr_cnt_r + CW'(1)));
                    end else begin
                        state_nxt = ST_FILL;
                    end
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            ST_HDR: begin
                if (m_hs_s) begin
                    seq_nxt     = seq_r + 8'd1;
                    m_data_nxt  = first_r;
                    out_idx_nxt = CW'(0);
                    state_nxt   = ST_PAYLOAD;
`ifdef TX_FRAMER_CSUM_EN
                    m_last_nxt  = 1'b0;
`else
                    m_last_nxt  = (len_r == CW'(1));
`endif
                end else begin
                    state_nxt = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (m_hs_s) begin
                    if (out_idx_r == len_r - CW'(1)) begin
`ifdef TX_FRAMER_CSUM_EN
                        m_data_nxt = csum_r;
                        m_last_nxt = 1'b1;
                        state_nxt  = ST_TRL;
`else
                        frame_end_s = 1'b1;
`endif
                    end else begin
                        m_data_nxt  = ram_q_s;
                        out_idx_nxt = out_idx_r + CW'(1);
                        rd_ptr_nxt  = rd_ptr_r + AW'(1);
`ifdef TX_FRAMER_CSUM_EN
                        m_last_nxt  = 1'b0;
`else
                        m_last_nxt  = (out_idx_r + CW'(2) == len_r);
`endif
                    end
                end else begin
                    state_nxt = ST_PAYLOAD;
                end
            end
`ifdef TX_FRAMER_CSUM_EN
            ST_TRL: begin
                if (m_hs_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    state_nxt = ST_TRL;
                end
            end
`endif
            ST_DROP: begin
                if (!drop_act_nxt) begin
                    state_nxt = ST_FILL;
                end else begin
                    state_nxt = ST_DROP;
                end
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase

        // Final framed beat accepted: release the buffer for the next frame.
        if (frame_end_s) begin
            m_valid_nxt   = 1'b0;
            m_last_nxt    = 1'b0;
            m_data_nxt    = 32'h0000_0000;
            frame_cnt_nxt = frame_cnt_r + 16'd1;
            wr_cnt_nxt    = CW'(0);
            rd_ptr_nxt    = AW'(1);
`ifdef TX_FRAMER_CSUM_EN
            csum_nxt      = 32'h0000_0000;
`endif
            state_nxt     = drop_act_nxt ? ST_DROP : ST_FILL;
        end else begin
            frame_cnt_nxt = frame_cnt_r;
        end

        s_ready_nxt = (state_nxt == ST_FILL) || (state_nxt == ST_DROP) || drop_act_nxt;
    end

    // State and datapath registers; reset discards any buffered frame.
    always_ff @(posedge axis_clk) begin
        if (rst) begin
            state_r      <= ST_FILL;
            drop_act_r   <= 1'b0;
            s_ready_r    <= 1'b0;
            m_valid_r    <= 1'b0;
            m_data_r     <= 32'h0000_0000;
            m_last_r     <= 1'b0;
            frame_cnt_r  <= 16'd0;
            drop_pulse_r <= 1'b0;
            seq_r        <= 8'd0;
            wr_cnt_r     <= CW'(0);
            len_r        <= CW'(0);
            out_idx_r    <= CW'(0);
            rd_ptr_r     <= AW'(1);
            first_r      <= 32'h0000_0000;
`ifdef TX_FRAMER_CSUM_EN
            csum_r       <= 32'h0000_0000;
`endif
        end else begin
            state_r      <= state_nxt;
            drop_act_r   <= drop_act_nxt;
            s_ready_r    <= s_ready_nxt;
            m_valid_r    <= m_valid_nxt;
            m_data_r     <= m_data_nxt;
            m_last_r     <= m_last_nxt;
            frame_cnt_r  <= frame_cnt_nxt;
            drop_pulse_r <= drop_pulse_nxt;
            seq_r        <= seq_nxt;
            wr_cnt_r     <= wr_cnt_nxt;
            len_r        <= len_nxt;
            out_idx_r    <= out_idx_nxt;
            rd_ptr_r     <= rd_ptr_nxt;
            first_r      <= first_nxt;
`ifdef TX_FRAMER_CSUM_EN
            csum_r       <= csum_nxt;
`endif
        end
    end

    assign s_axis_tready = s_ready_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tdata  = m_data_r;
    assign m_axis_tlast  = m_last_r;
    assign frame_cnt     = frame_cnt_r;
    assign drop_pulse    = drop_pulse_r;

endmodule

// File: tb/tb_axis_tx_framer.sv
// Table-driven bench for axis_tx_framer (FIFO_DEPTH=8): one record per frame with
// hand-computed header/checksum, plus hand-written reset sequences.
module tb_axis_tx_framer;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [15:0] frame_cnt;
    logic        drop_pulse;

    axis_tx_framer #(
        .U_DLY      (1),
        .FIFO_DEPTH (8)
    ) dut (
        .axis_clk      (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .frame_cnt     (frame_cnt),
        .drop_pulse    (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] first;
        logic [31:0] step;
        int          mode;
        logic [31:0] hdr;
        logic [31:0] csum;
        int          stored;
        int          pulses;
    } vec_t;

    vec_t        vecs [9];
    int          total;
    int          bad;
    int          cyc;
    logic [15:0] exp_frames;
    logic [15:0] ready_pat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int v, input int i);
        return vecs[v].first + vecs[v].step * 32'(i);
    endfunction

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        return ready_pat[cyc % 16];
    endfunction

    task automatic run_frame(input int v);
        logic [32:0] rx [$];
        int          rx_cyc [$];
        logic [32:0] expq [$];
        logic [32:0] tmp;
        logic [32:0] st;
        int          n, sidx, term_cyc, pulses;
        bit          stalled, fin, post_done, done;

        n = vecs[v].n;
        sidx = 0; term_cyc = -1; pulses = 0;
        stalled = 1'b0; fin = 1'b0; post_done = 1'b0; done = 1'b0;
        st = 33'd0;

        expq.push_back({1'b0, vecs[v].hdr});
        for (int i = 0; i < vecs[v].stored; i++) expq.push_back({1'b0, word_of(v, i)});
`ifdef TX_FRAMER_CSUM_EN
        expq.push_back({1'b0, vecs[v].csum});
`endif
        tmp = expq.pop_back();
        tmp[32] = 1'b1;
        expq.push_back(tmp);

        s_tvalid = 1'b1;
        s_tdata  = word_of(v, 0);
        s_tlast  = (n == 1);
        m_tready = pick_ready(vecs[v].mode);

        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            cyc++;
            if (drop_pulse) pulses++;
            if (s_tvalid && s_tready) begin
                sidx++;
                if (sidx == vecs[v].stored && term_cyc < 0) term_cyc = cyc;
            end
            if (fin) begin
                if (!post_done) begin
                    check($sformatf("v%0d_tready_reassert", v), 64'(s_tready), 64'd1);
                    check($sformatf("v%0d_valid_after_last", v), 64'(m_tvalid), 64'd0);
                    post_done = 1'b1;
                end
                if (sidx == n) done = 1'b1;
            end else begin
                if (stalled)
                    check($sformatf("v%0d_stall_hold", v), 64'({m_tvalid, m_tlast, m_tdata}),
                          64'({1'b1, st}));
                if (m_tvalid && m_tready) begin
                    rx.push_back({m_tlast, m_tdata});
                    rx_cyc.push_back(cyc);
                    stalled = 1'b0;
                    if (rx.size() == expq.size()) begin
                        check($sformatf("v%0d_tready_low_egress", v), 64'(s_tready), 64'd0);
                        fin = 1'b1;
                    end
                end else if (m_tvalid) begin
                    stalled = 1'b1;
                    st = {m_tlast, m_tdata};
                end else begin
                    stalled = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            if (sidx < n) begin
                s_tvalid = 1'b1;
                s_tdata  = word_of(v, sidx);
                s_tlast  = (sidx == n - 1);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            m_tready = pick_ready(vecs[v].mode);
        end

        check($sformatf("v%0d_frame_complete", v), 64'(done), 64'd1);
        check($sformatf("v%0d_beat_count", v), 64'(rx.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < rx.size(); i++)
            check($sformatf("v%0d_beat%0d", v, i), 64'(rx[i]), 64'(expq[i]));
        check($sformatf("v%0d_drop_pulses", v), 64'(pulses), 64'(vecs[v].pulses));
        exp_frames = exp_frames + 16'd1;
        check($sformatf("v%0d_frame_cnt", v), 64'(frame_cnt), 64'(exp_frames));
        if (vecs[v].mode == 0 && rx.size() > 0) begin
            check($sformatf("v%0d_hdr_latency", v), 64'(rx_cyc[0] - term_cyc), 64'd1);
            check($sformatf("v%0d_no_bubbles", v), 64'(rx_cyc[rx_cyc.size() - 1] - rx_cyc[0]),
                  64'(rx.size() - 1));
        end
    endtask

    initial begin
        int sidx;
        int hs;

        total = 0; bad = 0; cyc = 0;
        exp_frames = 16'd0;
        ready_pat  = 16'b1011_0010_0111_0100;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0; s_tlast = 1'b0; m_tready = 1'b0;

        //          n   first          step          mode hdr            csum           stored pulses
        vecs[0] = '{4,  32'h0000_0001, 32'h0000_0001, 0, 32'hA500_0004, 32'h0000_000A, 4, 0};
        vecs[1] = '{4,  32'h0000_0001, 32'h0000_0001, 0, 32'hA501_0004, 32'h0000_000A, 4, 0};
        vecs[2] = '{4,  32'h0000_0001, 32'h0000_0001, 1, 32'hA502_0004, 32'h0000_000A, 4, 0};
        vecs[3] = '{10, 32'h0000_0001, 32'h0000_0001, 0, 32'hA503_8008, 32'h0000_0024, 8, 1};
        vecs[4] = '{1,  32'hDEAD_BEEF, 32'h0000_0000, 0, 32'hA504_0001, 32'hDEAD_BEEF, 1, 0};
        vecs[5] = '{3,  32'h0000_0001, 32'h0000_0001, 1, 32'hA505_0003, 32'h0000_0006, 3, 0};
        vecs[6] = '{8,  32'h0000_0010, 32'h0000_0010, 0, 32'hA506_0008, 32'h0000_0240, 8, 0};
        vecs[7] = '{2,  32'hFFFF_FFFF, 32'h0000_0003, 1, 32'hA507_0002, 32'h0000_0001, 2, 0};
        vecs[8] = '{3,  32'h0000_0001, 32'h0000_0001, 0, 32'hA500_0003, 32'h0000_0006, 3, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({s_tready, m_tvalid, m_tlast, m_tdata, frame_cnt, drop_pulse}),
              64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_frame(v);

        // Six-word frame, reset while the third payload word is on the bus.
        sidx = 0; hs = 0;
        s_tvalid = 1'b1; s_tdata = 32'h0000_00C0; s_tlast = 1'b0; m_tready = 1'b1;
        for (int c = 0; c < 100 && hs < 3; c++) begin
            @(negedge clk);
            if (s_tvalid && s_tready) sidx++;
            if (m_tvalid && m_tready) hs++;
            @(posedge clk);
            #1;
            if (sidx < 6) begin
                s_tvalid = 1'b1;
                s_tdata  = 32'h0000_00C0 + 32'(sidx);
                s_tlast  = (sidx == 5);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        check("mid_frame_valid", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'h0000_00C2}));
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_payload", 64'({s_tready, m_tvalid, m_tlast, m_tdata, frame_cnt, drop_pulse}),
              64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frames = 16'd0;
        run_frame(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
